// File: rtl/fb_arbiter.sv
// fb_arbiter: shares a single-port framebuffer RAM between VGA scan-out and two round-robin writers.
// Optional FB_VBLANK_WRITE_ONLY_EN restricts writer slots to vertical blanking.
module fb_arbiter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int SHIFT  = 2,
    parameter int DW     = 8,
    parameter int AW     = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_en,
    input  logic                      display_en,
    input  logic                      vblank,
    input  logic [$clog2(HEIGHT)-1:0] row_pos,
    input  logic [$clog2(WIDTH)-1:0]  col_pos,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_wdata,
    input  logic [DW-1:0]             mem_rdata,
    output logic [DW-1:0]             pixel_out,
    output logic                      pixel_valid,
    input  logic                      wr0_valid,
    input  logic                      wr1_valid,
    input  logic [AW-1:0]             wr0_addr,
    input  logic [AW-1:0]             wr1_addr,
    input  logic [DW-1:0]             wr0_data,
    input  logic [DW-1:0]             wr1_data,
    output logic                      wr0_ready,
    output logic                      wr1_ready,
    output logic                      wr_drop
);
    localparam int unsigned FB_DEPTH = (WIDTH >> SHIFT) * (HEIGHT >> SHIFT);
    logic          rr, rd_q, vis_q, drop_q;
    logic [AW-1:0] addr_q, lin, gnt_addr;
    logic [DW-1:0] wdata_q, gnt_data;
    logic          disp_slot, wr_slot, gnt0, gnt1, gnt, drop;
    always_comb begin
        lin       = AW'(32'(row_pos >> SHIFT) * 32'(WIDTH >> SHIFT) + 32'(col_pos >> SHIFT));
        disp_slot = !rst && pix_en && display_en;
`ifdef FB_VBLANK_WRITE_ONLY_EN
        wr_slot   = !rst && !disp_slot && vblank;
`else
        wr_slot   = !rst && !disp_slot && (vblank | 1'b1);
`endif
        // rr=0 favours writer 0 when both request
        gnt0      = wr_slot && wr0_valid && (!wr1_valid || !rr);
        gnt1      = wr_slot && wr1_valid && !gnt0;
        gnt       = gnt0 || gnt1;
        gnt_addr  = gnt0 ? wr0_addr : wr1_addr;
        gnt_data  = gnt0 ? wr0_data : wr1_data;
        drop      = gnt && (32'(gnt_addr) >= FB_DEPTH);
        wr0_ready = gnt0;
        wr1_ready = gnt1;
        mem_en    = disp_slot || (gnt && !drop);
        mem_we    = gnt && !drop;
        mem_addr  = rst ? '0 : disp_slot ? lin : gnt ? gnt_addr : addr_q;
        mem_wdata = rst ? '0 : gnt ? gnt_data : wdata_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rr          <= 1'b0;
            rd_q        <= 1'b0;
            vis_q       <= 1'b0;
            drop_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
        end else begin
            rr      <= gnt ? gnt0 : rr;
            rd_q    <= pix_en;
            vis_q   <= display_en;
            drop_q  <= drop;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            // blank strobes also land here so pixel_out reads 0 outside active video
            if (rd_q) begin
                pixel_out   <= vis_q ? mem_rdata : '0;
                pixel_valid <= vis_q;
            end
        end
    end
    assign wr_drop = drop_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed plus randomized checks of fb_arbiter against a behavioural model.
module tb_fb_arbiter;
    logic        clk = 0, rst = 1;
    logic        pix_en = 0, display_en = 0, vblank = 0;
    logic [8:0]  row_pos = 0;
    logic [9:0]  col_pos = 0;
    logic        mem_en, mem_we, pixel_valid, wr0_ready, wr1_ready, wr_drop;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata, pixel_out;
    logic [7:0]  mem_rdata = 0;
    logic        wr0_valid = 0, wr1_valid = 0;
    logic [14:0] wr0_addr = 0, wr1_addr = 0;
    logic [7:0]  wr0_data = 0, wr1_data = 0;

    fb_arbiter dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .display_en(display_en), .vblank(vblank),
        .row_pos(row_pos), .col_pos(col_pos), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .wr0_valid(wr0_valid), .wr1_valid(wr1_valid), .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
        .wr0_data(wr0_data), .wr1_data(wr1_data), .wr0_ready(wr0_ready), .wr1_ready(wr1_ready),
        .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    typedef struct { int due; bit vis; } fetch_t;
    fetch_t      fq[$];
    int          n_chk = 0, n_err = 0, cyc = 0;
    int          turn = 0;
    logic [14:0] last_addr = 0;
    logic [7:0]  last_wdata = 0, pix_e = 0;
    logic        pv_e = 0, drop_e = 0, last_g0, last_g1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: compare every output with the model, then advance the model at the edge.
    task automatic tick();
        logic d, s, r0, r1, g, dr;
        logic [14:0] ga, ea;
        logic [7:0]  gd, ed;
        int lin;
        #1;
        lin = (int'(row_pos) / 4) * 160 + int'(col_pos) / 4;
        d = !rst && pix_en && display_en;
        s = !rst && !d;
`ifdef FB_VBLANK_WRITE_ONLY_EN
        s = s && vblank;
`endif
        r0 = s && wr0_valid && (!wr1_valid || turn == 0);
        r1 = s && wr1_valid && (!wr0_valid || turn == 1);
        g  = r0 || r1;
        ga = r0 ? wr0_addr : wr1_addr;
        gd = r0 ? wr0_data : wr1_data;
        dr = g && (int'(ga) >= 19200);
        ea = rst ? 15'd0 : d ? 15'(lin) : g ? ga : last_addr;
        ed = rst ? 8'd0 : g ? gd : last_wdata;
        chk("wr0_ready", wr0_ready, r0);
        chk("wr1_ready", wr1_ready, r1);
        chk("mem_en", mem_en, d || (g && !dr));
        chk("mem_we", mem_we, g && !dr);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("wr_drop", wr_drop, drop_e);
        chk("pixel_out", pixel_out, pix_e);
        chk("pixel_valid", pixel_valid, pv_e);
        @(posedge clk);
        last_g0 = r0;
        last_g1 = r1;
        if (rst) begin
            turn = 0; last_addr = 0; last_wdata = 0; drop_e = 0; pix_e = 0; pv_e = 0;
            fq.delete();
        end else begin
            last_addr = ea;
            last_wdata = ed;
            if (g) turn = r0 ? 1 : 0;
            drop_e = dr;
            if (fq.size() > 0 && fq[0].due == cyc) begin
                pix_e = fq[0].vis ? mem_rdata : 8'd0;
                pv_e  = fq[0].vis;
                void'(fq.pop_front());
            end
            if (pix_en) fq.push_back('{due: cyc + 1, vis: display_en});
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic p0, p1;
        @(posedge clk);
        @(negedge clk);
        repeat (3) tick();
        rst = 0;
        repeat (10) tick();
        #1;
        chk("idle_en", mem_en, 0);
        chk("idle_pv", pixel_valid, 0);
        // both writers held: alternating grants starting at writer 0
        wr0_valid = 1; wr0_addr = 10; wr0_data = 8'h11;
        wr1_valid = 1; wr1_addr = 20; wr1_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_addr", mem_addr, (i % 2) ? 20 : 10);
            chk("alt_r0", wr0_ready, (i % 2) == 0);
            chk("alt_we", mem_we, 1);
            tick();
        end
        wr0_valid = 0; wr1_valid = 0;
        // display fetch
        pix_en = 1; display_en = 1; row_pos = 5; col_pos = 9;
        #1;
        chk("disp_addr", mem_addr, 162);
        chk("disp_we", mem_we, 0);
        tick();
        pix_en = 0; mem_rdata = 8'hA5;
        tick();
        mem_rdata = 8'h00;
        #1;
        chk("disp_pix", pixel_out, 8'hA5);
        chk("disp_pv", pixel_valid, 1);
        tick();
        // writer blocked by a strobe, then served
        wr1_valid = 1; wr1_addr = 33; wr1_data = 8'h3C; pix_en = 1; display_en = 1;
        #1;
        chk("blk_r1", wr1_ready, 0);
        chk("blk_en", mem_en, 1);
        tick();
        pix_en = 0;
        #1;
        chk("srv_r1", wr1_ready, 1);
        chk("srv_we", mem_we, 1);
        chk("srv_addr", mem_addr, 33);
        tick();
        wr1_valid = 0;
        // out-of-range write is consumed and flagged
        wr0_valid = 1; wr0_addr = 15'd19200;
        #1;
        chk("drop_r0", wr0_ready, 1);
        chk("drop_we", mem_we, 0);
        tick();
        wr0_valid = 0;
        #1;
        chk("drop_pulse", wr_drop, 1);
        tick();
        #1;
        chk("drop_end", wr_drop, 0);
        tick();
`ifdef FB_VBLANK_WRITE_ONLY_EN
        vblank = 0; wr0_valid = 1; wr0_addr = 7;
        repeat (50) begin
            #1;
            chk("vb_stall", wr0_ready, 0);
            tick();
        end
        vblank = 1;
        #1;
        chk("vb_grant", wr0_ready, 1);
        tick();
        wr0_valid = 0;
`endif
        // randomized traffic, including occasional mid-operation resets
        p0 = 0; p1 = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            pix_en = ($urandom_range(0, 2) == 0);
            display_en = ($urandom_range(0, 3) != 0);
            vblank = $urandom_range(0, 1) == 1;
            row_pos = 9'($urandom_range(0, 479));
            col_pos = 10'($urandom_range(0, 639));
            mem_rdata = 8'($urandom);
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1;
                wr0_addr = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(19200, 32767)) : 15'($urandom_range(0, 19199));
                wr0_data = 8'($urandom);
            end
            if (!p1 && $urandom_range(0, 1) == 1) begin
                p1 = 1;
                wr1_addr = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(19200, 32767)) : 15'($urandom_range(0, 19199));
                wr1_data = 8'($urandom);
            end
            wr0_valid = p0;
            wr1_valid = p1;
            tick();
            if (last_g0) p0 = 0;
            if (last_g1) p1 = 0;
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between VGA scan-out and two game-logic writers (e.g. sprite engine, score renderer).
- Sits between the VGA timing generator (row/col position, display enable, pixel strobe) and the pixel DAC path.
- Display fetch has absolute priority on pixel-strobe cycles; all other cycles go to the writers under round-robin.
- Framebuffer is stored downscaled by 2^SHIFT in each axis.

Parameters:
- WIDTH, 640, active columns
- HEIGHT, 480, active rows
- SHIFT, 2, log2 downscale factor per axis
- DW, 8, pixel/RAM data width
- AW, 15, RAM address width; must satisfy 2^AW >= FB_DEPTH
- FB_DEPTH is derived, not a parameter: FB_DEPTH = (WIDTH>>SHIFT)*(HEIGHT>>SHIFT) = 19200 at defaults

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  one-clk strobe per pixel from timing generator
- display_en  in  1  active-video flag, aligned with pix_en
- vblank  in  1  vertical blanking flag
- row_pos  in  clog2(HEIGHT)  current row
- col_pos  in  clog2(WIDTH)  current column
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid 1 clk after a read enable
- pixel_out  out  DW  fetched pixel; 0 when blank
- pixel_valid  out  1  pixel_out holds a fetched pixel
- wr0_valid, wr1_valid  in  1  write request
- wr0_addr, wr1_addr  in  AW  linear framebuffer address
- wr0_data, wr1_data  in  DW  write data
- wr0_ready, wr1_ready  out  1  grant; handshake completes when valid && ready in the same clk
- wr_drop  out  1  one-clk pulse: accepted write had address >= FB_DEPTH

Behaviour:
- Reset is synchronous. All outputs are 0 during and after reset. The round-robin pointer resets to writer 0.
- Slot selection is per clk and is combinational from registered state plus inputs.
- Display slot: pix_en && display_en.
  - Drive mem_en=1, mem_we=0.
  - mem_addr = (row_pos>>SHIFT)*(WIDTH>>SHIFT) + (col_pos>>SHIFT).
  - Both readies are 0.
- Writer slot: any cycle that is not a display slot, and is not gated by the optional feature.
  - If exactly one wrN_valid is high, grant it.
  - If both are high, grant the writer the RR pointer indicates. After an accepted grant, the pointer moves to the other writer.
  - The pointer updates only on an accepted grant.
  - Granted writer: wrN_ready=1, mem_en=1, mem_we=1, mem_addr=wrN_addr, mem_wdata=wrN_data.
  - If wrN_addr >= FB_DEPTH: mem_en=0, mem_we=0, ready still 1 (request consumed), wr_drop=1 on the next clk.
- Idle: mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last value.
- Writers must hold valid, addr and data stable until ready. ready never depends on the same writer's data.
- Read pipeline, for a display slot at cycle T:
  - RAM returns data at T+1.
  - pixel_out and pixel_valid are registered on the edge ending T+1 and are visible in T+2.
  - Fixed latency is 2 clk.
- pix_en with display_en=0: pixel_out=0, pixel_valid=0, visible at the same 2-clk latency. Between pix_en strobes, pixel_out holds its value.
- Arithmetic: the address product is computed at full width, then truncated to AW. Row/col inputs beyond WIDTH/HEIGHT are not checked; the timing generator guarantees range.
- Reset mid-operation: in-flight reads are discarded and pixel_valid=0 on the next clk. A writer whose ready was high in the reset cycle is not written.

Optional Feature:
- Macro: FB_VBLANK_WRITE_ONLY_EN.
- Defined: writer slots also require vblank=1. With vblank=0, both readies are 0 and the write stalls, giving tear-free updates.
- Undefined: the vblank input is ignored, and every non-display cycle is a writer slot.

Test Plan:
- Reset, then idle for 10 clk:
  - All outputs are 0.
  - After reset, with both writers valid and no pix_en, wr0 is granted first.
- Display fetch, row_pos=5, col_pos=9, pix_en=1, display_en=1 at T:
  - mem_addr=162, mem_we=0 at T.
  - Bench drives mem_rdata=0xA5 at T+1.
  - pixel_out=0xA5 and pixel_valid=1 at T+2.
- Both writers held valid continuously, wr0_addr=10, wr1_addr=20, no display slots:
  - Grants alternate wr0, wr1, wr0, wr1.
  - mem_addr sequence is 10, 20, 10, 20, with mem_we=1.
- wr1_valid=1 in a cycle with pix_en=1, display_en=1:
  - wr1_ready=0 and a read is issued.
  - Next clk (no strobe): wr1_ready=1 and the write is issued.
- wr0_addr=19200:
  - wr0_ready=1, mem_we=0.
  - wr_drop=1 for exactly one clk.
- With FB_VBLANK_WRITE_ONLY_EN and vblank=0, wr0_valid=1 for 50 clk:
  - wr0_ready stays 0.
  - Raising vblank grants wr0 in the same clk.
